// File: rtl/button_conditioner.sv
// button_conditioner
// Turns a raw, asynchronous, bouncy push-button line into a clean debounced level.
// It also produces single-cycle event pulses for press, release and long press.
// The press pulse feeds a light controller directly, giving one toggle per physical press.
// The release event is on port release_pulse, because "release" is a reserved word.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int CNT_W             = 16
) (
  input  logic clk,
  input  logic reset,          // asynchronous, active low
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  state_t           state_reg, state_next;
  logic             sync_meta_reg, btn_sync_reg;
  logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             rel_reg, rel_next;
  logic             long_reg, long_next;

  // Two-flop synchroniser; the FSM only ever looks at btn_sync_reg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_reg <= 1'b0;
      btn_sync_reg  <= 1'b0;
    end else begin
      sync_meta_reg <= btn_raw;
      btn_sync_reg  <= sync_meta_reg;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      deb_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      level_reg    <= 1'b0;
      press_reg    <= 1'b0;
      rel_reg      <= 1'b0;
      long_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      deb_cnt_reg  <= deb_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      level_reg    <= level_next;
      press_reg    <= press_next;
      rel_reg      <= rel_next;
      long_reg     <= long_next;
    end
  end

  // Next-state logic.
  // The pulses default to 0, so each one can be high for only one cycle.
  // hold_cnt only advances while in PRESSED, so a bounce into RELEASE_WAIT freezes it.
  always_comb begin
    state_next    = state_reg;
    deb_cnt_next  = deb_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    level_next    = level_reg;
    press_next    = 1'b0;
    rel_next      = 1'b0;
    long_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (btn_sync_reg) begin
          state_next   = PRESS_WAIT;
          deb_cnt_next = ONE;
        end
      end

      PRESS_WAIT: begin
        if (!btn_sync_reg) begin
          state_next   = IDLE;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next    = PRESSED;
          deb_cnt_next  = '0;
          hold_cnt_next = '0;
          level_next    = 1'b1;
          press_next    = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + ONE;
        end
      end

      PRESSED: begin
        if (hold_cnt_reg < HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + ONE;
          long_next     = (hold_cnt_reg == HOLD_LAST);
        end
        if (!btn_sync_reg) begin
          state_next   = RELEASE_WAIT;
          deb_cnt_next = ONE;
        end
      end

      RELEASE_WAIT: begin
        if (btn_sync_reg) begin
          state_next   = PRESSED;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = IDLE;
          deb_cnt_next = '0;
          level_next   = 1'b0;
          rel_next     = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + ONE;
        end
      end

      default: begin
        state_next   = IDLE;
        deb_cnt_next = '0;
        level_next   = 1'b0;
      end
    endcase
  end

  assign btn_level     = level_reg;
  assign press         = press_reg;
  assign release_pulse = rel_reg;
  assign long_press    = long_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Directed stimulus pushes the expected event pulses, each with its hand-computed cycle,
// onto a scoreboard queue. An independent monitor pops and compares each pulse the DUT emits.
// A small toggle flop stands in for the light controller driven by press.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 16;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level, press, release_pulse, long_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .CNT_W            (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; an event "at cycle N" is visible after edge N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Light-controller stand-in: one toggle per press pulse.
  logic light = 1'b0;
  always @(posedge clk) if (press) light <= ~light;
  int exp_light = 0;

  typedef struct {
    int kind;   // 0 press, 1 release, 2 long_press
    int at;
  } ev_t;
  ev_t exp_q[$];

  int passed = 0;
  int total  = 0;

  function automatic string kname(int k);
    case (k)
      0:       return "press";
      1:       return "release";
      default: return "long_press";
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic expect_ev(int k, int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    exp_q.push_back(e);
    if (k == 0) exp_light ^= 1;
  endtask

  task automatic wait_until(int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every pulse the DUT shows must match the head of the scoreboard.
  int  mon_n;
  int  mon_k;
  ev_t mon_e;
  always @(negedge clk) begin
    mon_n = int'(press) + int'(release_pulse) + int'(long_press);
    if (mon_n > 0) begin
      if (mon_n > 1) check("pulse_exclusive", mon_n, 1);
      mon_k = press ? 0 : (release_pulse ? 1 : 2);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: got %s at cycle %0d, required none", kname(mon_k), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check({kname(mon_e.kind), "_kind"}, mon_k, mon_e.kind);
        check({kname(mon_e.kind), "_cycle"}, cyc, mon_e.at);
        $display("event %s at cycle %0d (expected %s at %0d)", kname(mon_k), cyc,
                 kname(mon_e.kind), mon_e.at);
      end
    end
  end

  int r, t, t0;

  initial begin
    // 1. Reset held with button pressed, then release reset and keep holding.
    reset   = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_level", int'(btn_level), 0);
    check("reset_press", int'(press), 0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_long", int'(long_press), 0);
    r = cyc;
    reset = 1'b1;
    expect_ev(0, r + 6);
    wait_until(r + 5);
    check("t1_level_before_latency", int'(btn_level), 0);
    wait_until(r + 6);
    check("t1_level_after_latency", int'(btn_level), 1);
    wait_until(r + 8);
    btn_raw = 1'b0;
    expect_ev(1, r + 14);
    wait_until(r + 13);
    check("t1_level_before_release", int'(btn_level), 1);
    wait_until(r + 14);
    check("t1_level_after_release", int'(btn_level), 0);
    wait_until(r + 20);
    check("t1_light", int'(light), exp_light);

    // 2. Clean 40-cycle press: press, long_press 16 cycles later, release.
    t0 = cyc;
    btn_raw = 1'b1;
    expect_ev(0, t0 + 6);
    expect_ev(2, t0 + 22);
    wait_until(t0 + 40);
    check("t2_level_held", int'(btn_level), 1);
    btn_raw = 1'b0;
    expect_ev(1, t0 + 46);
    wait_until(t0 + 55);
    check("t2_level_idle", int'(btn_level), 0);
    check("t2_light", int'(light), exp_light);

    // 3a. Glitches of 1..3 cycles from idle: no events, level stays low.
    for (int k = 1; k <= 3; k++) begin
      t = cyc;
      btn_raw = 1'b1;
      repeat (k) @(negedge clk);
      btn_raw = 1'b0;
      wait_until(t + 12);
      check($sformatf("t3_glitch%0d_level", k), int'(btn_level), 0);
    end

    // 3b. A 4-cycle pulse is just long enough to be accepted.
    t = cyc;
    btn_raw = 1'b1;
    expect_ev(0, t + 6);
    repeat (4) @(negedge clk);
    btn_raw = 1'b0;
    expect_ev(1, t + 10);
    wait_until(t + 16);
    check("t3_boundary_level", int'(btn_level), 0);

    // 3c. One-cycle and three-cycle drops while pressed.
    // Each frozen RELEASE_WAIT cycle delays long_press by one cycle.
    t0 = cyc;
    btn_raw = 1'b1;
    expect_ev(0, t0 + 6);
    expect_ev(2, t0 + 26);
    wait_until(t0 + 12);
    btn_raw = 1'b0;
    wait_until(t0 + 13);
    btn_raw = 1'b1;
    wait_until(t0 + 16);
    btn_raw = 1'b0;
    wait_until(t0 + 19);
    btn_raw = 1'b1;
    wait_until(t0 + 21);
    check("t3_drop_level", int'(btn_level), 1);
    wait_until(t0 + 40);
    btn_raw = 1'b0;
    expect_ev(1, t0 + 46);
    wait_until(t0 + 55);
    check("t3_drop_level_idle", int'(btn_level), 0);
    check("t3_light", int'(light), exp_light);

    // 5. Press held 10 cycles: press and release, no long_press.
    t0 = cyc;
    btn_raw = 1'b1;
    expect_ev(0, t0 + 6);
    wait_until(t0 + 16);
    btn_raw = 1'b0;
    expect_ev(1, t0 + 22);
    wait_until(t0 + 30);
    check("t5_level_idle", int'(btn_level), 0);
    check("t5_light", int'(light), exp_light);

    // 6. Reset mid-PRESSED: outputs drop at once with no release pulse.
    // The button is still held after reset, so it counts as a fresh press.
    t0 = cyc;
    btn_raw = 1'b1;
    expect_ev(0, t0 + 6);
    wait_until(t0 + 12);
    check("t6_level_pressed", int'(btn_level), 1);
    reset = 1'b0;
    #1;
    check("t6_level_in_reset", int'(btn_level), 0);
    check("t6_queue_in_reset", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    r = cyc;
    reset = 1'b1;
    expect_ev(0, r + 6);
    wait_until(r + 5);
    check("t6_level_before_latency", int'(btn_level), 0);
    wait_until(r + 6);
    check("t6_level_after_latency", int'(btn_level), 1);
    wait_until(r + 8);
    btn_raw = 1'b0;
    expect_ev(1, r + 14);
    wait_until(r + 20);
    check("t6_level_idle", int'(btn_level), 0);
    check("t6_light", int'(light), exp_light);

    repeat (10) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
